// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and counter sizing.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } seqState_t;

    // Smallest width able to hold 0..maxVal, never less than one bit.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous level signals into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up sequencer: pulses the PLL reset, qualifies LOCK, then releases domain resets in order.
// Lock timeout with bounded retries and a FAIL state is built only when PLL_SEQ_TIMEOUT_EN is defined.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = 3,
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP         = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   soft_rst,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   ready,
    output logic                   fail,
    output logic [1:0]             retry_cnt
);

    localparam int RstW  = cntWidth(RST_CYCLES);
    localparam int StabW = cntWidth(LOCK_STABLE_CYCLES);
    localparam int GapW  = cntWidth(RELEASE_GAP);
    localparam int IdxW  = cntWidth(NUM_DOMAINS);

    if (NUM_DOMAINS < 1 || RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || RELEASE_GAP < 1 ||
        LOCK_TIMEOUT_CYCLES < 1 || MAX_RETRIES < 0 || MAX_RETRIES > 3) begin : g_badParams
        $error("pll_reset_sequencer: illegal parameter set");
    end

    seqState_t              state_q;
    logic [RstW-1:0]        rstCnt_q;
    logic [StabW-1:0]       stableCnt_q;
    logic [GapW-1:0]        gapCnt_q;
    logic [IdxW-1:0]        domIdx_q;
    logic                   pllRst_q;
    logic [NUM_DOMAINS-1:0] domRst_q;
    logic                   ready_q;
    logic                   lock_s;

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam int ToW = cntWidth(LOCK_TIMEOUT_CYCLES);
    logic [ToW-1:0] toCnt_q;
    logic [1:0]     retry_q;
    logic           fail_q;
`endif

    sync_2ff #(.WIDTH(1)) u_lockSync (
        .clk   (clk),
        .reset (reset),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    // Outputs are registered together with the state so a lock loss reaches dom_rst one edge after lock_s.
    always_ff @(posedge clk) begin
        if (reset || soft_rst) begin
            state_q     <= PLL_RST;
            rstCnt_q    <= '0;
            stableCnt_q <= '0;
            gapCnt_q    <= '0;
            domIdx_q    <= '0;
            pllRst_q    <= 1'b1;
            domRst_q    <= '1;
            ready_q     <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
            toCnt_q     <= '0;
            retry_q     <= '0;
            fail_q      <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                PLL_RST: begin
                    if (rstCnt_q == RstW'(RST_CYCLES - 1)) begin
                        state_q  <= WAIT_LOCK;
                        rstCnt_q <= '0;
                        pllRst_q <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
                        toCnt_q  <= '0;
`endif
                    end else begin
                        rstCnt_q <= rstCnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q     <= STABLE;
                        stableCnt_q <= '0;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_q     <= WAIT_LOCK;
                        stableCnt_q <= '0;
                    end else if (stableCnt_q == StabW'(LOCK_STABLE_CYCLES - 1)) begin
                        state_q     <= (NUM_DOMAINS == 1) ? RUN : RELEASE;
                        stableCnt_q <= stableCnt_q + 1'b1;
                        domRst_q    <= domRst_q << 1;
                        domIdx_q    <= IdxW'(1);
                        gapCnt_q    <= '0;
                    end else begin
                        stableCnt_q <= stableCnt_q + 1'b1;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_s) begin
                        state_q     <= PLL_RST;
                        rstCnt_q    <= '0;
                        stableCnt_q <= '0;
                        gapCnt_q    <= '0;
                        domIdx_q    <= '0;
                        pllRst_q    <= 1'b1;
                        domRst_q    <= '1;
                    end else if (state_q == RUN) begin
                        ready_q <= 1'b1;
                    end else if (gapCnt_q == GapW'(RELEASE_GAP - 1)) begin
                        // Shifting a zero in from bit 0 keeps the release strictly in index order.
                        domRst_q <= domRst_q << 1;
                        gapCnt_q <= '0;
                        if (domIdx_q == IdxW'(NUM_DOMAINS - 1)) begin
                            state_q <= RUN;
                        end else begin
                            domIdx_q <= domIdx_q + 1'b1;
                        end
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
`ifdef PLL_SEQ_TIMEOUT_EN
                FAIL: begin
                    pllRst_q <= 1'b1;
                end
`endif
                default: begin
                    state_q  <= PLL_RST;
                    pllRst_q <= 1'b1;
                    domRst_q <= '1;
                end
            endcase

`ifdef PLL_SEQ_TIMEOUT_EN
            // The timeout spans WAIT_LOCK and STABLE, so lock chatter cannot stall the sequence forever.
            if (state_q == WAIT_LOCK || state_q == STABLE) begin
                if (toCnt_q == ToW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    toCnt_q     <= '0;
                    rstCnt_q    <= '0;
                    stableCnt_q <= '0;
                    pllRst_q    <= 1'b1;
                    domRst_q    <= '1;
                    if (retry_q != 2'd3) begin
                        retry_q <= retry_q + 1'b1;
                    end
                    if (retry_q == 2'(MAX_RETRIES)) begin
                        state_q <= FAIL;
                        fail_q  <= 1'b1;
                    end else begin
                        state_q <= PLL_RST;
                    end
                end else begin
                    toCnt_q <= toCnt_q + 1'b1;
                end
            end
`endif
        end
    end

    assign pll_rst = pllRst_q;
    assign dom_rst = domRst_q;
    assign ready   = ready_q;

`ifdef PLL_SEQ_TIMEOUT_EN
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
`else
    assign fail      = 1'b0;
    assign retry_cnt = 2'b00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer; the timeout scenario runs only with PLL_SEQ_TIMEOUT_EN.
module tb_pll_reset_sequencer;

    localparam int NDOM = 3;
    localparam int RSTC = 4;
    localparam int STAB = 8;
    localparam int GAP  = 2;
    localparam int TOUT = 50;
    localparam int MAXR = 2;

    typedef struct {
        int         cyc;
        logic [2:0] dom;
        logic       rdy;
    } expEvent_t;

    logic            clk        = 1'b0;
    logic            reset      = 1'b1;
    logic            pll_locked = 1'b0;
    logic            soft_rst   = 1'b0;
    logic            pll_rst;
    logic [NDOM-1:0] dom_rst;
    logic            ready;
    logic            fail;
    logic [1:0]      retry_cnt;

    int        cycle  = 0;
    int        checks = 0;
    int        errors = 0;
    expEvent_t expQ[$];
    expEvent_t monEv;
    logic      monEn  = 1'b0;
    logic [3:0] prevObs;

    pll_reset_sequencer #(
        .NUM_DOMAINS         (NDOM),
        .RST_CYCLES          (RSTC),
        .LOCK_STABLE_CYCLES  (STAB),
        .RELEASE_GAP         (GAP),
        .LOCK_TIMEOUT_CYCLES (TOUT),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .pll_rst    (pll_rst),
        .dom_rst    (dom_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Every change of {dom_rst, ready} must match the next expected event, including its cycle.
    always @(negedge clk) begin
        if (monEn && ({dom_rst, ready} !== prevObs)) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: cycle %0d dom_rst=%b ready=%b, no change expected",
                         cycle, dom_rst, ready);
            end else begin
                monEv = expQ.pop_front();
                if (monEv.cyc != cycle || monEv.dom !== dom_rst || monEv.rdy !== ready) begin
                    errors++;
                    $display("[TB] FAIL sb_event: got cycle %0d dom_rst=%b ready=%b, want cycle %0d dom_rst=%b ready=%b",
                             cycle, dom_rst, ready, monEv.cyc, monEv.dom, monEv.rdy);
                end
            end
            prevObs = {dom_rst, ready};
        end
    end

    task automatic pushRelease(input int rel);
        expQ.push_back('{rel,             3'b110, 1'b0});
        expQ.push_back('{rel + GAP,       3'b100, 1'b0});
        expQ.push_back('{rel + 2 * GAP,   3'b000, 1'b0});
        expQ.push_back('{rel + 2 * GAP + 1, 3'b000, 1'b1});
    endtask

    task automatic test_reset();
        int hiCnt;
        while (cycle < 3) @(negedge clk);
        checks++;
        if (pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_pll_rst: got %b, want 1", pll_rst); end
        checks++;
        if (dom_rst !== 3'b111) begin errors++; $display("[TB] FAIL reset_dom_rst: got %b, want 111", dom_rst); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b, want 0", ready); end
        checks++;
        if (fail !== 1'b0) begin errors++; $display("[TB] FAIL reset_fail: got %b, want 0", fail); end
        checks++;
        if (retry_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_retry: got %0d, want 0", retry_cnt); end
        reset   = 1'b0;
        prevObs = {dom_rst, ready};
        monEn   = 1'b1;
        pushRelease(10 + 3 + STAB);
        hiCnt = 0;
        while (pll_rst === 1'b1 && hiCnt < 50) begin
            hiCnt++;
            @(negedge clk);
        end
        checks++;
        if (hiCnt != RSTC) begin errors++; $display("[TB] FAIL reset_pulse_width: got %0d cycles, want %0d", hiCnt, RSTC); end
        while (cycle < 10) @(negedge clk);
        pll_locked = 1'b1;
        for (int i = 0; i < 60 && expQ.size() != 0; i++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL reset_drain: %0d events pending, want 0", expQ.size()); expQ.delete(); end
        checks++;
        if (ready !== 1'b1 || pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL reset_run: ready=%b pll_rst=%b, want 1/0", ready, pll_rst); end
    endtask

    task automatic test_lock_loss();
        int t0;
        int hiCnt;
        repeat (3) @(negedge clk);
        t0 = cycle;
        pll_locked = 1'b0;
        expQ.push_back('{t0 + 3, 3'b111, 1'b0});
        while (cycle < t0 + 2) @(negedge clk);
        checks++;
        if (pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL lossEarlyPllRst: got %b, want 0", pll_rst); end
        @(negedge clk);
        hiCnt = 0;
        while (pll_rst === 1'b1 && hiCnt < 50) begin
            hiCnt++;
            @(negedge clk);
        end
        checks++;
        if (hiCnt != RSTC) begin errors++; $display("[TB] FAIL loss_pulse_width: got %0d cycles, want %0d", hiCnt, RSTC); end
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL loss_drain: %0d events pending, want 0", expQ.size()); expQ.delete(); end
    endtask

    task automatic test_glitch();
        int c3;
        c3 = cycle;
        pll_locked = 1'b1;
        while (cycle < c3 + 6) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        pushRelease(c3 + 7 + 3 + STAB);
        for (int i = 0; i < 60 && expQ.size() != 0; i++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL glitch_drain: %0d events pending, want 0", expQ.size()); expQ.delete(); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL glitch_ready: got %b, want 1", ready); end
    endtask

    task automatic test_soft_release();
        int s;
        int rel;
        s = cycle;
        soft_rst = 1'b1;
        expQ.push_back('{s + 1, 3'b111, 1'b0});
        @(negedge clk);
        soft_rst = 1'b0;
        checks++;
        if (pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL soft_pll_rst: got %b, want 1", pll_rst); end
        rel = s + 1 + RSTC + 1 + STAB;
        expQ.push_back('{rel,     3'b110, 1'b0});
        expQ.push_back('{rel + 1, 3'b111, 1'b0});
        while (cycle < rel) @(negedge clk);
        checks++;
        if (dom_rst !== 3'b110) begin errors++; $display("[TB] FAIL soft_mid_release: got %b, want 110", dom_rst); end
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        checks++;
        if (dom_rst !== 3'b111 || pll_rst !== 1'b1) begin
            errors++;
            $display("[TB] FAIL soft_abort: dom_rst=%b pll_rst=%b, want 111/1", dom_rst, pll_rst);
        end
        pushRelease(rel + 1 + RSTC + 1 + STAB);
        for (int i = 0; i < 60 && expQ.size() != 0; i++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL soft_drain: %0d events pending, want 0", expQ.size()); expQ.delete(); end
    endtask

`ifdef PLL_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int t0;
        int to1;
        int to2;
        int to3;
        int f;
        logic heldOk;
        t0 = cycle;
        pll_locked = 1'b0;
        expQ.push_back('{t0 + 3, 3'b111, 1'b0});
        to1 = t0 + 3 + RSTC + TOUT;
        to2 = to1 + RSTC + TOUT;
        to3 = to2 + RSTC + TOUT;
        while (cycle < to1 - 1) @(negedge clk);
        checks++;
        if (retry_cnt !== 2'd0 || pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL to1_before: retry=%0d pll_rst=%b, want 0/0", retry_cnt, pll_rst); end
        @(negedge clk);
        checks++;
        if (retry_cnt !== 2'd1 || pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL to1_after: retry=%0d pll_rst=%b, want 1/1", retry_cnt, pll_rst); end
        while (cycle < to2 - 1) @(negedge clk);
        checks++;
        if (retry_cnt !== 2'd1) begin errors++; $display("[TB] FAIL to2_before: retry=%0d, want 1", retry_cnt); end
        @(negedge clk);
        checks++;
        if (retry_cnt !== 2'd2) begin errors++; $display("[TB] FAIL to2_after: retry=%0d, want 2", retry_cnt); end
        while (cycle < to3 - 1) @(negedge clk);
        checks++;
        if (fail !== 1'b0 || pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL to3_before: fail=%b pll_rst=%b, want 0/0", fail, pll_rst); end
        @(negedge clk);
        checks++;
        if (fail !== 1'b1 || pll_rst !== 1'b1 || retry_cnt !== 2'd3) begin
            errors++;
            $display("[TB] FAIL to3_fail: fail=%b pll_rst=%b retry=%0d, want 1/1/3", fail, pll_rst, retry_cnt);
        end
        heldOk = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (fail !== 1'b1 || pll_rst !== 1'b1 || dom_rst !== 3'b111) heldOk = 1'b0;
        end
        checks++;
        if (!heldOk) begin errors++; $display("[TB] FAIL fail_hold: fail=%b pll_rst=%b dom_rst=%b, want 1/1/111 held", fail, pll_rst, dom_rst); end
        f = cycle;
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        checks++;
        if (fail !== 1'b0 || retry_cnt !== 2'd0 || pll_rst !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fail_clear: fail=%b retry=%0d pll_rst=%b, want 0/0/1", fail, retry_cnt, pll_rst);
        end
        while (cycle < f + RSTC) @(negedge clk);
        checks++;
        if (pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL restart_pulse_end: got %b, want 1", pll_rst); end
        @(negedge clk);
        checks++;
        if (pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL restart_pulse_fall: got %b, want 0", pll_rst); end
    endtask
`else
    task automatic test_no_timeout();
        int t0;
        int c;
        t0 = cycle;
        pll_locked = 1'b0;
        expQ.push_back('{t0 + 3, 3'b111, 1'b0});
        while (cycle < t0 + 3 + RSTC) @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checks++;
            if (pll_rst !== 1'b0 || fail !== 1'b0 || retry_cnt !== 2'd0) begin
                errors++;
                $display("[TB] FAIL wait_forever: cycle %0d pll_rst=%b fail=%b retry=%0d, want 0/0/0",
                         cycle, pll_rst, fail, retry_cnt);
            end
        end
        c = cycle;
        pll_locked = 1'b1;
        pushRelease(c + 3 + STAB);
        for (int i = 0; i < 60 && expQ.size() != 0; i++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL late_lock_drain: %0d events pending, want 0", expQ.size()); expQ.delete(); end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_lock_loss();
        test_glitch();
        test_soft_release();
`ifdef PLL_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL final_queue: %0d events pending, want 0", expQ.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
